// File: rtl/serial_full_adder_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module : sfa_pkg
// Brief  : Shared types and helpers for the bit-serial adder/subtractor.
// Rev    : 1.0  initial release
// ============================================================================
package sfa_pkg;

  // Controller states; the encoding width is fixed at two bits.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width.  The counter must index bits 0..width-1.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_full_adder_acc_if.sv
`default_nettype none
// ============================================================================
// Module : serial_full_adder_acc_if
// Brief  : Operand/result handshake bundle for the bit-serial adder.
//          The master drives requests, the slave (the adder) returns results.
// Rev    : 1.0  initial release
// ============================================================================
interface serial_full_adder_acc_if #(
  parameter int WIDTH = 8
) ();

  logic             ena;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output ena, start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  ena, start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface
`default_nettype wire

// File: rtl/serial_full_adder_acc_fa_bit_cell.sv
`default_nettype none
// ============================================================================
// Module : fa_bit_cell
// Brief  : One-bit full adder; the only arithmetic cell in the serial adder.
// Rev    : 1.0  initial release
// ============================================================================
module fa_bit_cell (
  input  wire logic a,
  input  wire logic b,
  input  wire logic ci,
  output logic      s,
  output logic      co
);

  // Sum bit and majority carry.
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule
`default_nettype wire

// File: rtl/serial_full_adder_acc.sv
`default_nettype none
// ============================================================================
// Module : serial_full_adder_acc
// Brief  : Bit-serial adder/subtractor.  Operands load in parallel on an
//          accepted start, then one bit per enabled clock is summed LSB-first
//          through a single full-adder cell.  Result, carry-out and signed
//          overflow are held from done until the next accepted start.
// Rev    : 1.0  initial release
// ============================================================================
module serial_full_adder_acc
  import sfa_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SUB_EN = 1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  serial_full_adder_acc_if.slave bus
);

  localparam int              CNT_W  = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_sub;
  logic             w_s;
  logic             w_co;

  // Subtract request is forced low when the build is add-only.
  assign w_sub = bus.sub & (SUB_EN != 0);

  fa_bit_cell u_cell (
    .a  (r_op_a[0]),
    .b  (r_op_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // Controller, operand/sum shifters and held result registers; ena=0 pauses all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (bus.ena) begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            // Subtraction is a + ~b + 1; cin then flips so cin=1 means a-b-1.
            r_op_a   <= bus.a;
            r_op_b   <= w_sub ? ~bus.b : bus.b;
            r_carry  <= bus.cin ^ w_sub;
            r_cnt    <= '0;
            r_sum_sh <= '0;
            r_sum    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_state  <= IDLE;
          end
        end
        RUN: begin
          r_op_a   <= r_op_a >> 1;
          r_op_b   <= r_op_b >> 1;
          r_carry  <= w_co;
          r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
          if (r_cnt == C_LAST) begin
            // Final bit: publish the whole result and flags at once.
            r_sum   <= {w_s, r_sum_sh[WIDTH-1:1]};
            r_cout  <= w_co;
            r_ovf   <= r_carry ^ w_co;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_full_adder_acc.sv
`default_nettype none
// ============================================================================
// Module : tb_serial_full_adder_acc
// Brief  : Self-checking bench for the bit-serial adder (WIDTH=8).  A second
//          add-only instance shadows every operation of the main instance.
// Rev    : 1.0  initial release
// ============================================================================
module tb_serial_full_adder_acc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  serial_full_adder_acc_if #(.WIDTH(8)) bus ();
  serial_full_adder_acc_if #(.WIDTH(8)) bus_ns ();

  serial_full_adder_acc #(.WIDTH(8), .SUB_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  serial_full_adder_acc #(.WIDTH(8), .SUB_EN(0)) dut_ns (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_ns)
  );

  assign bus_ns.ena   = bus.ena;
  assign bus_ns.start = bus.start;
  assign bus_ns.sub   = bus.sub;
  assign bus_ns.a     = bus.a;
  assign bus_ns.b     = bus.b;
  assign bus_ns.cin   = bus.cin;

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  // Reference: plain 9-bit arithmetic; overflow from operand/result signs.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic s);
    logic [7:0] bb;
    logic [8:0] r;
    logic       ov;
    bb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + 9'(c ^ s);
    ov = (a[7] == bb[7]) && (r[7] != a[7]);
    return {ov, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Issue one request and wait for done; lat counts negedges after the accept edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic s, input bit now, input int stall_at,
                        input int poke_at, output int lat);
    if (!now) @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = c; bus.sub = s; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    chk("busy after accept", bus.busy, 1);
    chk("sum cleared on accept", bus.sum, 0);
    while (bus.done !== 1'b1 && lat < 60) begin
      if (lat == stall_at) bus.ena = 1'b0;
      if (lat == stall_at + 4) bus.ena = 1'b1;
      if (lat == poke_at) begin
        bus.start = 1'b1; bus.a = ~a; bus.b = ~b; bus.sub = ~s; bus.cin = ~c;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.ena = 1'b1;
    bus.start = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic c, input logic s, input logic [9:0] exp,
                              input int lat, input int exp_lat);
    logic [9:0] m_ns;
    m_ns = model(a, b, c, 1'b0);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " sum"}, bus.sum, exp[7:0]);
    chk({name, " cout"}, bus.cout, exp[8]);
    chk({name, " ovf"}, bus.ovf, exp[9]);
    chk({name, " addonly done"}, bus_ns.done, 1);
    chk({name, " addonly result"}, {bus_ns.ovf, bus_ns.cout, bus_ns.sum}, m_ns);
  endtask

  task automatic op_check(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic s, input logic [9:0] exp,
                          input int stall_at, input int poke_at, input int exp_lat);
    int lat;
    run_op(a, b, c, s, 1'b0, stall_at, poke_at, lat);
    check_result(name, a, b, c, s, exp, lat, exp_lat);
    @(negedge clk);
    chk({name, " done pulse"}, bus.done, 0);
    chk({name, " idle busy"}, bus.busy, 0);
  endtask

  vec_t tbl[6];

  initial begin
    int         lat;
    logic [7:0] ra, rb;
    logic       rc, rs;
    int         st;

    tbl[0] = '{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[4] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hEF, 1'b0, 1'b0};
    tbl[5] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};

    bus.ena = 1'b1; bus.start = 1'b0; bus.sub = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset result", {bus.ovf, bus.cout, bus.sum}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset idle", {bus.busy, bus.done}, 0);

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      op_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
               {tbl[i].ovf, tbl[i].cout, tbl[i].sum}, -1, -1, 9);
    end

    // Back-to-back: new start presented in the done cycle.
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, -1, -1, lat);
    check_result("b2b first", 8'hFF, 8'h01, 1'b0, 1'b0, 10'h100, lat, 9);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, -1, -1, lat);
    check_result("b2b second", 8'h01, 8'h01, 1'b0, 1'b0, 10'h002, lat, 9);

    // done held while paused in DONE, drops on the next enabled edge.
    bus.ena = 1'b0;
    @(negedge clk);
    chk("done held paused 1", bus.done, 1);
    @(negedge clk);
    chk("done held paused 2", bus.done, 1);
    bus.ena = 1'b1;
    @(negedge clk);
    chk("done drops after pause", bus.done, 0);
    chk("sum held in idle", bus.sum, 8'h02);

    // Four paused cycles during RUN add exactly four cycles.
    op_check("stall", 8'h5A, 8'h33, 1'b0, 1'b0, 10'h28D, 3, -1, 13);

    // Start plus operand changes while busy are ignored.
    op_check("poke", 8'h10, 8'h20, 1'b0, 1'b1, 10'h0F0, -1, 4, 9);

    // Reset at the third RUN bit; flags from a prior op must clear.
    op_check("pre-reset", 8'h80, 8'h01, 1'b0, 1'b1, 10'h37F, -1, -1, 9);
    bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("cout/ovf held over accept", {bus.ovf, bus.cout}, 2'b11);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midop reset busy", bus.busy, 0);
    chk("midop reset result", {bus.done, bus.ovf, bus.cout, bus.sum}, 0);
    @(negedge clk);
    chk("midop reset stays idle", {bus.busy, bus.done}, 0);
    rst_n = 1'b1;
    op_check("after reset", 8'h22, 8'h11, 1'b1, 1'b0, 10'h034, -1, -1, 9);

    // Random regression against the arithmetic model.
    for (int i = 0; i < 120; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1;
      op_check($sformatf("rand%0d", i), ra, rb, rc, rs, model(ra, rb, rc, rs),
               st, -1, (st < 0) ? 9 : 13);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
